// File: rtl/cim_pkg.sv
// Shared definitions for the CIM command sequencer and its array-side datapath.
package cim_pkg;
    localparam int DATA_W = 8;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_VADD  = 3'd3;
    localparam logic [2:0] OP_VSUB  = 3'd4;
    localparam logic [2:0] OP_VAND  = 3'd5;
    localparam logic [2:0] OP_VOR   = 3'd6;
    localparam logic [2:0] OP_VXOR  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_A,
        S_RD_B,
        S_CAP,
        S_DONE
    } state_t;
endpackage

// File: rtl/cim_vector_alu.sv
// Element-wise vector ALU: pure combinational op(a, b); non-vector opcodes yield zero.
module cim_vector_alu
    import cim_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_VADD: y = a + b;
            OP_VSUB: y = a - b;
            OP_VAND: y = a & b;
            OP_VOR:  y = a | b;
            OP_VXOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cim_vector_sequencer.sv
// Command sequencer: turns one accepted command into the SRAM read/write cycles it needs,
// walking VLEN elements for vector ops and reporting a single 8-bit result.
module cim_vector_sequencer
    import cim_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int VLEN   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_a,
    input  logic [ADDR_W-1:0]   cmd_b,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data
);

    localparam int              CNT_W = $clog2(VLEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VLEN - 1);

    state_t              state, nxt;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   a_q, b_q, dst_q, off;
    logic [DATA_W-1:0]   wdata_q, a_word, alu_y;
    logic [CNT_W-1:0]    cnt;
    logic                accept, is_write, is_read, last;

    assign accept   = (state == S_IDLE) && cmd_valid;
    assign is_write = (op_q == OP_WRITE);
    assign is_read  = (op_q == OP_READ);
    assign last     = (cnt == LAST);
    // Element offset wraps with the address width, giving mod 2**ADDR_W addressing.
    assign off      = ADDR_W'(cnt);

    cim_vector_alu u_alu (
        .op (op_q),
        .a  (a_word),
        .b  (mem_rdata),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_op == OP_NOP)        nxt = S_DONE;
                    else if (cmd_op == OP_WRITE) nxt = S_WR;
                    else                         nxt = S_RD_A;
                end
            end
            S_RD_A: begin
                mem_addr = is_read ? dst_q : a_q + off;
                nxt      = is_read ? S_CAP : S_RD_B;
            end
            S_RD_B: begin
                mem_addr = b_q + off;
                nxt      = S_WR;
            end
            S_WR: begin
                mem_we    = 1'b1;
                mem_addr  = dst_q + off;
                mem_wdata = is_write ? wdata_q : alu_y;
                nxt       = (is_write || last) ? S_DONE : S_RD_A;
            end
            S_CAP:   nxt = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                nxt       = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            dst_q    <= '0;
            wdata_q  <= '0;
            a_word   <= '0;
            cnt      <= '0;
            res_data <= '0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op;
                a_q     <= cmd_a;
                b_q     <= cmd_b;
                dst_q   <= cmd_dst;
                wdata_q <= cmd_wdata;
                cnt     <= '0;
                if (cmd_op == OP_NOP) res_data <= '0;
            end
            case (state)
                // A word arrives the cycle after its RD_A address; B word is on the bus in WR.
                S_RD_B: a_word <= mem_rdata;
                S_CAP:  res_data <= mem_rdata;
                S_WR: begin
                    if (is_write) begin
                        res_data <= wdata_q;
                    end else begin
                        if (last) res_data <= alu_y;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_vector_sequencer.sv
// Scoreboard bench: issuing a command pushes the reference-model result and its due cycle;
// a negedge monitor pops and compares on every res_valid.
module tb_cim_vector_sequencer;
    localparam int ADDR_W = 4;
    localparam int VLEN   = 4;
    localparam int DEPTH  = 16;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk, rst, cmd_valid, cmd_ready, mem_we, busy, res_valid;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_a, cmd_b, cmd_dst, mem_addr;
    logic [7:0]  cmd_wdata, mem_wdata, mem_rdata, res_data;

    logic [7:0]  sram    [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    cim_vector_sequencer #(.ADDR_W(ADDR_W), .VLEN(VLEN)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_wdata(cmd_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .res_valid(res_valid), .res_data(res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) sram[mem_addr] <= mem_wdata;
        mem_rdata <= sram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", res_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_cycle", cyc, e.cyc);
                end
            end
            if (mem_we) check("we_outside_busy", busy, 1);
        end
    end

    function automatic logic [7:0] op_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd3:    return x + y;
            3'd4:    return x - y;
            3'd5:    return x & y;
            3'd6:    return x | y;
            3'd7:    return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    // Reference behaviour: result word and latency from accept edge to res_valid.
    task automatic model(input logic [2:0] op, input int a, input int b, input int dst,
                         input logic [7:0] wd, output logic [7:0] d, output int lat);
        d = 8'h00;
        case (op)
            3'd0: lat = 1;
            3'd1: begin ref_mem[dst] = wd; d = wd; lat = 2; end
            3'd2: begin d = ref_mem[dst]; lat = 3; end
            default: begin
                for (int i = 0; i < VLEN; i++) begin
                    d = op_ref(op, ref_mem[(a + i) % DEPTH], ref_mem[(b + i) % DEPTH]);
                    ref_mem[(dst + i) % DEPTH] = d;
                end
                lat = 3 * VLEN + 1;
            end
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] dst, input logic [7:0] wd, input bit use_model,
                         output int t_acc);
        int         guard;
        int         lat;
        logic [7:0] d;
        exp_t       e;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst; cmd_wdata = wd;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            t_acc = -1;
            return;
        end
        t_acc = cyc + 1;
        if (use_model) begin
            model(op, int'(a), int'(b), int'(dst), wd, d, lat);
            e.data = d;
            e.cyc  = t_acc + lat - 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_dst = 4'($urandom); cmd_wdata = 8'($urandom);
    endtask

    initial begin
        int         t, t_vx, t_rd, guard;
        logic [3:0] seq[$];
        logic [7:0] pre2;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; cmd_dst = '0; cmd_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) issue(3'd1, 4'd0, 4'd0, 4'(i), 8'($urandom), 1, t);

        issue(3'd1, 4'd0, 4'd0, 4'd3, 8'hA5, 1, t);
        issue(3'd2, 4'd0, 4'd0, 4'd3, 8'h00, 1, t);

        issue(3'd1, 0, 0, 4'd0, 8'hFF, 1, t);
        issue(3'd1, 0, 0, 4'd1, 8'h01, 1, t);
        issue(3'd1, 0, 0, 4'd2, 8'h02, 1, t);
        issue(3'd1, 0, 0, 4'd3, 8'h03, 1, t);
        for (int i = 4; i < 8; i++) issue(3'd1, 0, 0, 4'(i), 8'h01, 1, t);
        issue(3'd3, 4'd0, 4'd4, 4'd8, 8'h00, 1, t);

        issue(3'd5, 4'd14, 4'd6, 4'd0, 8'h00, 1, t);
        for (int i = 0; i < VLEN; i++) begin
            seq.push_back(4'd14 + 4'(i));
            seq.push_back(4'd6 + 4'(i));
            seq.push_back(4'd0 + 4'(i));
        end
        foreach (seq[k]) begin
            @(negedge clk);
            check("addr_seq", mem_addr, seq[k]);
        end

        issue(3'd7, 4'd1, 4'd9, 4'd10, 8'h00, 1, t_vx);
        issue(3'd2, 4'd0, 4'd0, 4'd13, 8'h00, 1, t_rd);
        check("stall_accept", t_rd, t_vx + 3 * VLEN + 2);

        issue(3'd7, 4'd2, 4'd2, 4'd2, 8'h00, 1, t);
        issue(3'd0, 4'd5, 4'd5, 4'd5, 8'h77, 1, t);

        for (int n = 0; n < 30; n++)
            issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                  8'($urandom), 1, t);

        issue(3'd1, 0, 0, 4'd15, 8'h5A, 1, t);
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        issue(3'd4, 4'd0, 4'd4, 4'd12, 8'h00, 0, t);
        pre2 = ref_mem[0] - ref_mem[4];
        ref_mem[12] = pre2;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_res_data", res_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_we", mem_we, 0);
        end
        issue(3'd0, 0, 0, 0, 8'h00, 1, t);
        issue(3'd2, 0, 0, 4'd12, 8'h00, 1, t);

        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain", exp_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) check("mem_final", sram[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
